// File: rtl/rx_packet_dispatcher_pkg.sv
// Shared constants for the receive-side dispatcher: FSM state codes,
// timeout status bit and the default response timeout.
package rx_packet_dispatcher_pkg;

   typedef enum logic [1:0] {
      HC_ACT        = 2'b00,
      SC_ACT        = 2'b01,
      DISP_WAIT_REQ = 2'b10,
      START_DISP    = 2'b11
   } dispState_t;

   localparam int RX_TIME_OUT_BIT    = 6;
   localparam int RX_TIMEOUT_DEFAULT = 72;   // 18 FS bit times at 48 MHz

   // Status byte reported to a client whose packet never arrived.
   localparam logic [7:0] RX_TIME_OUT_STATUS = 8'(1 << RX_TIME_OUT_BIT);

endpackage

// File: rtl/rx_packet_dispatcher_if.sv
// Client handshakes and receive-processor bus of the dispatcher.
// master = clients plus processor side, slave = the dispatcher itself.
interface rx_packet_dispatcher_if;

   logic       HC_req;
   logic       HC_gnt;
   logic       HC_rx_en;
   logic       HC_rx_rdy;
   logic       SC_req;
   logic       SC_gnt;
   logic       SC_rx_en;
   logic       SC_rx_rdy;
   logic       rx_en;
   logic       rx_rdy;
   logic [3:0] rx_pid;
   logic [7:0] rx_status;
   logic [3:0] rx_pid_q;
   logic [7:0] rx_status_q;

   modport master (
      output HC_req, HC_rx_en, SC_req, SC_rx_en, rx_rdy, rx_pid, rx_status,
      input  HC_gnt, HC_rx_rdy, SC_gnt, SC_rx_rdy, rx_en, rx_pid_q, rx_status_q
   );

   modport slave (
      input  HC_req, HC_rx_en, SC_req, SC_rx_en, rx_rdy, rx_pid, rx_status,
      output HC_gnt, HC_rx_rdy, SC_gnt, SC_rx_rdy, rx_en, rx_pid_q, rx_status_q
   );

endinterface

// File: rtl/rx_packet_dispatcher_timeout.sv
// 16-bit response timeout counter: synchronous clear, increment, and a
// terminal-count flag when the count reaches TIMEOUT_CYCLES-1.
module rx_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 72
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic termCnt
);

   localparam logic [15:0] CNT_TC = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Count enabled cycles; clear has priority over increment.
   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc)
         count <= count + 16'd1;
   end

   assign termCnt = (count == CNT_TC);

endmodule

// File: rtl/rx_packet_dispatcher.sv
// Shares one receive-packet processor between the host controller (HC)
// and the slave controller (SC). HC has fixed priority; the owner keeps
// the processor until it drops its req. A timeout releases a client
// waiting on a packet that never arrives.
module rx_packet_dispatcher
   import rx_packet_dispatcher_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = RX_TIMEOUT_DEFAULT
) (
   input logic                   clk,
   input logic                   rst,
   rx_packet_dispatcher_if.slave bus
);

   dispState_t state, nextState;
   logic       muxSCNotHC, muxNext;
   logic       toLatched;
   logic       grantAct;
   logic       selReq;
   logic       selRxEn;
   logic       rxEnInt;
   logic       capture;
   logic       timeoutHit;
   logic       termCnt;
   logic       cntClr;

   assign grantAct = (state == HC_ACT) || (state == SC_ACT);
   assign selReq   = muxSCNotHC ? bus.SC_req   : bus.HC_req;
   assign selRxEn  = muxSCNotHC ? bus.SC_rx_en : bus.HC_rx_en;

   // A latched timeout masks the owner's stale enable so the processor
   // is not re-armed until the owner drops rx_en or req.
   assign rxEnInt    = selRxEn & grantAct & ~toLatched;
   assign capture    = rxEnInt & bus.rx_rdy;
   assign timeoutHit = rxEnInt & termCnt & ~bus.rx_rdy;   // real packet wins

   assign bus.rx_en  = rxEnInt;
   assign bus.HC_gnt = (state == HC_ACT);
   assign bus.SC_gnt = (state == SC_ACT);

   // State and mux-select register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= START_DISP;
         muxSCNotHC <= 1'b0;
      end else begin
         state      <= nextState;
         muxSCNotHC <= muxNext;
      end
   end

   // Arbitration: fixed HC priority, owner holds until its req drops.
   always_comb begin
      nextState = state;
      muxNext   = muxSCNotHC;
      case (state)
         START_DISP:    nextState = DISP_WAIT_REQ;
         DISP_WAIT_REQ: begin
            if (bus.HC_req) begin
               nextState = HC_ACT;
               muxNext   = 1'b0;
            end else if (bus.SC_req) begin
               nextState = SC_ACT;
               muxNext   = 1'b1;
            end
         end
         HC_ACT, SC_ACT: if (!selReq) nextState = DISP_WAIT_REQ;
         default:        nextState = START_DISP;
      endcase
   end

   // Timeout latch: set on terminal count, cleared by the owner backing off.
   always_ff @(posedge clk) begin
      if (rst)
         toLatched <= 1'b0;
      else if (!grantAct || !selReq || !selRxEn)
         toLatched <= 1'b0;
      else if (timeoutHit)
         toLatched <= 1'b1;
   end

   assign cntClr = ~rxEnInt | ~selReq | capture | timeoutHit;

   rx_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (cntClr),
      .inc     (rxEnInt),
      .termCnt (termCnt)
   );

   // Result capture and one-cycle ready pulse to the owner only.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.HC_rx_rdy   <= 1'b0;
         bus.SC_rx_rdy   <= 1'b0;
         bus.rx_pid_q    <= '0;
         bus.rx_status_q <= '0;
      end else begin
         bus.HC_rx_rdy <= (capture | timeoutHit) & ~muxSCNotHC;
         bus.SC_rx_rdy <= (capture | timeoutHit) &  muxSCNotHC;
         if (capture) begin
            bus.rx_pid_q    <= bus.rx_pid;
            bus.rx_status_q <= bus.rx_status;
         end else if (timeoutHit) begin
            bus.rx_pid_q    <= 4'h0;
            bus.rx_status_q <= RX_TIME_OUT_STATUS;
         end
      end
   end

endmodule

// File: tb/tb_rx_packet_dispatcher.sv
// Directed bench for rx_packet_dispatcher: arbitration, capture,
// timeout, rdy/timeout collision and mid-packet reset.
module tb_rx_packet_dispatcher;
   import rx_packet_dispatcher_pkg::*;

   localparam int TO = 72;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rx_packet_dispatcher_if bus ();

   rx_packet_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.HC_gnt !== 1'b0) begin failures++; $display("FAIL reset_hc_gnt got=%0b exp=0", bus.HC_gnt); end
      checks++; if (bus.SC_gnt !== 1'b0) begin failures++; $display("FAIL reset_sc_gnt got=%0b exp=0", bus.SC_gnt); end
      checks++; if ({bus.HC_rx_rdy, bus.SC_rx_rdy, bus.rx_en} !== 3'b000) begin failures++; $display("FAIL reset_rdy_en got=%b exp=000", {bus.HC_rx_rdy, bus.SC_rx_rdy, bus.rx_en}); end
      checks++; if ({bus.rx_pid_q, bus.rx_status_q} !== 12'h000) begin failures++; $display("FAIL reset_q got=%h exp=000", {bus.rx_pid_q, bus.rx_status_q}); end
      checks++; if (dut.state !== START_DISP) begin failures++; $display("FAIL reset_state got=%b exp=%b", dut.state, START_DISP); end
      // Release reset with HC requesting: grant lands on the second edge.
      rst = 1'b0;
      bus.HC_req = 1'b1;
      tick();
      checks++; if (bus.HC_gnt !== 1'b0) begin failures++; $display("FAIL grant_early got=%0b exp=0", bus.HC_gnt); end
      tick();
      checks++; if (bus.HC_gnt !== 1'b1) begin failures++; $display("FAIL grant_hc got=%0b exp=1", bus.HC_gnt); end
      checks++; if (bus.SC_gnt !== 1'b0) begin failures++; $display("FAIL grant_sc_idle got=%0b exp=0", bus.SC_gnt); end
      checks++; if (bus.rx_en !== 1'b0) begin failures++; $display("FAIL rx_en_no_client_en got=%0b exp=0", bus.rx_en); end
      bus.HC_rx_en = 1'b1;
      #1;
      checks++; if (bus.rx_en !== 1'b1) begin failures++; $display("FAIL rx_en_hc got=%0b exp=1", bus.rx_en); end
   endtask

   task automatic test_capture();
      repeat (10) tick();
      bus.rx_pid    = 4'h2;
      bus.rx_status = 8'h00;
      bus.rx_rdy    = 1'b1;
      tick();
      bus.rx_rdy = 1'b0;
      checks++; if (bus.HC_rx_rdy !== 1'b1) begin failures++; $display("FAIL cap_hc_rdy got=%0b exp=1", bus.HC_rx_rdy); end
      checks++; if (bus.SC_rx_rdy !== 1'b0) begin failures++; $display("FAIL cap_sc_rdy got=%0b exp=0", bus.SC_rx_rdy); end
      checks++; if ({bus.rx_pid_q, bus.rx_status_q} !== 12'h200) begin failures++; $display("FAIL cap_q got=%h exp=200", {bus.rx_pid_q, bus.rx_status_q}); end
      tick();
      checks++; if (bus.HC_rx_rdy !== 1'b0) begin failures++; $display("FAIL cap_pulse_width got=%0b exp=0", bus.HC_rx_rdy); end
      // rx_rdy with the enable off is ignored.
      bus.HC_rx_en = 1'b0;
      bus.rx_pid   = 4'h5;
      bus.rx_rdy   = 1'b1;
      tick();
      bus.rx_rdy = 1'b0;
      checks++; if ({bus.HC_rx_rdy, bus.rx_pid_q} !== 5'b0_0010) begin failures++; $display("FAIL cap_ignored got=%b exp=00010", {bus.HC_rx_rdy, bus.rx_pid_q}); end
   endtask

   task automatic test_priority();
      bus.HC_req = 1'b0;
      tick();
      checks++; if (bus.HC_gnt !== 1'b0) begin failures++; $display("FAIL release_hc got=%0b exp=0", bus.HC_gnt); end
      bus.HC_req = 1'b1;
      bus.SC_req = 1'b1;
      tick();
      checks++; if ({bus.HC_gnt, bus.SC_gnt} !== 2'b10) begin failures++; $display("FAIL prio_both got=%b exp=10", {bus.HC_gnt, bus.SC_gnt}); end
      repeat (3) tick();
      checks++; if ({bus.HC_gnt, bus.SC_gnt} !== 2'b10) begin failures++; $display("FAIL prio_hold got=%b exp=10", {bus.HC_gnt, bus.SC_gnt}); end
      bus.HC_req = 1'b0;
      tick();
      checks++; if ({bus.HC_gnt, bus.SC_gnt} !== 2'b00) begin failures++; $display("FAIL prio_wait got=%b exp=00", {bus.HC_gnt, bus.SC_gnt}); end
      tick();
      checks++; if ({bus.HC_gnt, bus.SC_gnt} !== 2'b01) begin failures++; $display("FAIL prio_sc got=%b exp=01", {bus.HC_gnt, bus.SC_gnt}); end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      bus.SC_rx_en = 1'b1;
      for (int k = 1; k < TO; k++) begin
         tick();
         if (bus.SC_rx_rdy !== 1'b0 || bus.rx_en !== 1'b1) early++;
      end
      checks++; if (early != 0) begin failures++; $display("FAIL to_early got=%0d exp=0", early); end
      tick();
      checks++; if ({bus.SC_rx_rdy, bus.HC_rx_rdy} !== 2'b10) begin failures++; $display("FAIL to_pulse got=%b exp=10", {bus.SC_rx_rdy, bus.HC_rx_rdy}); end
      checks++; if ({bus.rx_pid_q, bus.rx_status_q} !== 12'h040) begin failures++; $display("FAIL to_q got=%h exp=040", {bus.rx_pid_q, bus.rx_status_q}); end
      checks++; if (bus.rx_en !== 1'b0) begin failures++; $display("FAIL to_mask got=%0b exp=0", bus.rx_en); end
      tick();
      checks++; if ({bus.SC_rx_rdy, bus.rx_en} !== 2'b00) begin failures++; $display("FAIL to_after got=%b exp=00", {bus.SC_rx_rdy, bus.rx_en}); end
      bus.SC_rx_en = 1'b0;
      tick();
      bus.SC_rx_en = 1'b1;
      #1;
      checks++; if (bus.rx_en !== 1'b1) begin failures++; $display("FAIL to_rearm got=%0b exp=1", bus.rx_en); end
   endtask

   task automatic test_rdy_on_terminal();
      // rx_en has just risen with the counter at zero.
      repeat (TO - 1) tick();
      bus.rx_pid    = 4'h3;
      bus.rx_status = 8'h01;
      bus.rx_rdy    = 1'b1;
      tick();
      bus.rx_rdy = 1'b0;
      checks++; if (bus.SC_rx_rdy !== 1'b1) begin failures++; $display("FAIL tc_rdy got=%0b exp=1", bus.SC_rx_rdy); end
      checks++; if ({bus.rx_pid_q, bus.rx_status_q} !== 12'h301) begin failures++; $display("FAIL tc_q got=%h exp=301", {bus.rx_pid_q, bus.rx_status_q}); end
      checks++; if (bus.rx_en !== 1'b1) begin failures++; $display("FAIL tc_no_mask got=%0b exp=1", bus.rx_en); end
      tick();
      checks++; if (bus.SC_rx_rdy !== 1'b0) begin failures++; $display("FAIL tc_single got=%0b exp=0", bus.SC_rx_rdy); end
   endtask

   task automatic test_reset_mid();
      bus.SC_req   = 1'b0;
      bus.SC_rx_en = 1'b0;
      tick();
      bus.HC_req = 1'b1;
      tick();
      bus.HC_rx_en = 1'b1;
      repeat (5) tick();
      checks++; if ({bus.HC_gnt, bus.rx_en} !== 2'b11) begin failures++; $display("FAIL mid_setup got=%b exp=11", {bus.HC_gnt, bus.rx_en}); end
      rst = 1'b1;
      tick();
      checks++; if ({bus.HC_gnt, bus.SC_gnt, bus.HC_rx_rdy, bus.SC_rx_rdy, bus.rx_en} !== 5'b00000) begin failures++; $display("FAIL mid_outputs got=%b exp=00000", {bus.HC_gnt, bus.SC_gnt, bus.HC_rx_rdy, bus.SC_rx_rdy, bus.rx_en}); end
      checks++; if ({bus.rx_pid_q, bus.rx_status_q} !== 12'h000) begin failures++; $display("FAIL mid_q got=%h exp=000", {bus.rx_pid_q, bus.rx_status_q}); end
      checks++; if (dut.state !== START_DISP) begin failures++; $display("FAIL mid_state got=%b exp=%b", dut.state, START_DISP); end
      rst = 1'b0;
      bus.rx_pid    = 4'h7;
      bus.rx_status = 8'h11;
      bus.rx_rdy    = 1'b1;
      tick();
      bus.rx_rdy = 1'b0;
      checks++; if ({bus.HC_rx_rdy, bus.rx_pid_q} !== 5'b0_0000) begin failures++; $display("FAIL mid_late_rdy got=%b exp=00000", {bus.HC_rx_rdy, bus.rx_pid_q}); end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.HC_req    = 1'b0;
      bus.HC_rx_en  = 1'b0;
      bus.SC_req    = 1'b0;
      bus.SC_rx_en  = 1'b0;
      bus.rx_rdy    = 1'b0;
      bus.rx_pid    = 4'h0;
      bus.rx_status = 8'h00;
      test_reset();
      test_capture();
      test_priority();
      test_timeout();
      test_rdy_on_terminal();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
